// File: rtl/dual_sram_responder.sv
// dual_sram_responder: request/done front end for two asynchronous 16-bit SRAM banks.
// addr[16] picks the bank; the request is captured once, then a fixed strobe
// sequence runs and completes with a four-phase done handshake.
// Optional build macro SRAM_LONG_WE_EN: stretches the write pulse to two cycles.
//
// state   | meaning
// IDLE    | waiting for en with re/we
// W_SETUP | bank enabled, write data on bus, WE high
// W_PULSE | WE low (1 cycle, 2 with SRAM_LONG_WE_EN)
// W_END   | WE back high, data still driven
// R_SETUP | bank enabled, OE low, bus released
// R_WAIT  | OE held low for RD_WAIT cycles (skipped when RD_WAIT=0)
// R_LATCH | bus captured into data_out
// DONE    | done high, strobes idle, wait for re=we=0
//
// Strobes and done are registered from the current state, so the pins show
// each state one cycle after the FSM enters it. done is the exception on the
// way out: it drops on the same edge that returns the FSM to IDLE.
module dual_sram_responder #(
  parameter int RD_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        re,
  input  logic        we,
  input  logic [16:0] addr,
  input  logic [15:0] data_in,
  output logic        done,
  output logic [15:0] data_out,
  output logic [17:0] ram_addr1,
  output logic [17:0] ram_addr2,
  inout  wire  [15:0] ram_data1,
  inout  wire  [15:0] ram_data2,
  output logic        ram1EN,
  output logic        ram2EN,
  output logic        ram1OE,
  output logic        ram2OE,
  output logic        ram1WE,
  output logic        ram2WE
);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_END, R_SETUP, R_WAIT, R_LATCH, DONE
  } state_t;

`ifdef SRAM_LONG_WE_EN
  localparam logic [2:0] WE_LOAD = 3'd1;
`else
  localparam logic [2:0] WE_LOAD = 3'd0;
`endif

  localparam int         RD_LOAD_I = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;
  localparam logic [2:0] RD_LOAD   = RD_LOAD_I[2:0];

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        accept;
  logic        bank_q;
  logic [15:0] wdata_q;
  logic        drv1, drv2;
  logic        sel_active, sel_drive, sel_we, sel_oe;

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (en && (we || re)) begin
          accept    = 1'b1;
          state_nxt = we ? W_SETUP : R_SETUP;
        end
      end
      W_SETUP: begin
        state_nxt = W_PULSE;
        cnt_nxt   = WE_LOAD;
      end
      W_PULSE: begin
        if (cnt == 3'd0) state_nxt = W_END;
        else             cnt_nxt   = cnt - 3'd1;
      end
      W_END:   state_nxt = DONE;
      R_SETUP: begin
        if (RD_WAIT == 0) begin
          state_nxt = R_LATCH;
        end else begin
          state_nxt = R_WAIT;
          cnt_nxt   = RD_LOAD;
        end
      end
      R_WAIT: begin
        if (cnt == 3'd0) state_nxt = R_LATCH;
        else             cnt_nxt   = cnt - 3'd1;
      end
      R_LATCH: state_nxt = DONE;
      DONE: begin
        // done must have been seen high before the handshake can close
        if (done && !re && !we) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobe intent for the selected bank, decoded from the current state
  always_comb begin
    sel_active = 1'b0;
    sel_drive  = 1'b0;
    sel_we     = 1'b0;
    sel_oe     = 1'b0;
    case (state)
      W_SETUP: begin sel_active = 1'b1; sel_drive = 1'b1; end
      W_PULSE: begin sel_active = 1'b1; sel_drive = 1'b1; sel_we = 1'b1; end
      W_END:   begin sel_active = 1'b1; sel_drive = 1'b1; end
      R_SETUP, R_WAIT, R_LATCH: begin sel_active = 1'b1; sel_oe = 1'b1; end
      default: ;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture; addresses hold until the next accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q    <= 1'b0;
      wdata_q   <= 16'h0000;
      ram_addr1 <= 18'h00000;
      ram_addr2 <= 18'h00000;
    end else if (accept) begin
      bank_q  <= addr[16];
      wdata_q <= data_in;
      if (addr[16]) ram_addr2 <= {2'b00, addr[15:0]};
      else          ram_addr1 <= {2'b00, addr[15:0]};
    end
  end

  // Registered strobes, bus drive enables and done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram1EN <= 1'b1;
      ram2EN <= 1'b1;
      ram1OE <= 1'b1;
      ram2OE <= 1'b1;
      ram1WE <= 1'b1;
      ram2WE <= 1'b1;
      drv1   <= 1'b0;
      drv2   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ram1EN <= !(sel_active && !bank_q);
      ram2EN <= !(sel_active &&  bank_q);
      ram1OE <= !(sel_oe     && !bank_q);
      ram2OE <= !(sel_oe     &&  bank_q);
      ram1WE <= !(sel_we     && !bank_q);
      ram2WE <= !(sel_we     &&  bank_q);
      drv1   <= sel_drive && !bank_q;
      drv2   <= sel_drive &&  bank_q;
      done   <= (state == DONE) && (state_nxt == DONE);
    end
  end

  // Read capture; OE has been low for at least one cycle at this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= 16'h0000;
    end else if (state == R_LATCH) begin
      data_out <= bank_q ? ram_data2 : ram_data1;
    end
  end

  assign ram_data1 = drv1 ? wdata_q : 16'hzzzz;
  assign ram_data2 = drv2 ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_dual_sram_responder.sv
// Directed bench for dual_sram_responder: two behavioural SRAMs on the default
// instance, plus a second instance with RD_WAIT=3 reading a fixed pattern.
module tb_dual_sram_responder;

`ifdef SRAM_LONG_WE_EN
  localparam int W_LAT  = 5;
  localparam int WE_CYC = 2;
`else
  localparam int W_LAT  = 4;
  localparam int WE_CYC = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, re = 1'b0, we = 1'b0;
  logic        en3 = 1'b0, re3 = 1'b0, we3 = 1'b0;
  logic [16:0] addr = '0;
  logic [15:0] data_in = '0;

  logic        done, done3;
  logic [15:0] data_out, data_out3;
  logic [17:0] ram_addr1, ram_addr2, ra1_3, ra2_3;
  wire  [15:0] ram_data1, ram_data2, rd1_3, rd2_3;
  logic        ram1EN, ram2EN, ram1OE, ram2OE, ram1WE, ram2WE;
  logic        r1en3, r2en3, r1oe3, r2oe3, r1we3, r2we3;

  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dual_sram_responder dut (
    .clk(clk), .rst(rst), .en(en), .re(re), .we(we), .addr(addr), .data_in(data_in),
    .done(done), .data_out(data_out), .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_data1(ram_data1), .ram_data2(ram_data2),
    .ram1EN(ram1EN), .ram2EN(ram2EN), .ram1OE(ram1OE), .ram2OE(ram2OE),
    .ram1WE(ram1WE), .ram2WE(ram2WE)
  );

  dual_sram_responder #(.RD_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .re(re3), .we(we3), .addr(addr), .data_in(data_in),
    .done(done3), .data_out(data_out3), .ram_addr1(ra1_3), .ram_addr2(ra2_3),
    .ram_data1(rd1_3), .ram_data2(rd2_3),
    .ram1EN(r1en3), .ram2EN(r2en3), .ram1OE(r1oe3), .ram2OE(r2oe3),
    .ram1WE(r1we3), .ram2WE(r2we3)
  );

  // SRAM models: write on the rising edge of WE, drive bus while EN and OE low
  always @(posedge ram1WE) if (!ram1EN) mem1[ram_addr1[7:0]] <= ram_data1;
  always @(posedge ram2WE) if (!ram2EN) mem2[ram_addr2[7:0]] <= ram_data2;
  assign ram_data1 = (!ram1EN && !ram1OE) ? mem1[ram_addr1[7:0]] : 16'hzzzz;
  assign ram_data2 = (!ram2EN && !ram2OE) ? mem2[ram_addr2[7:0]] : 16'hzzzz;
  assign rd1_3 = (!r1en3 && !r1oe3) ? 16'hA5A5 : 16'hzzzz;
  assign rd2_3 = (!r2en3 && !r2oe3) ? 16'h5A5A : 16'hzzzz;

  // Issue one request from a negedge; scramble addr/data after acceptance.
  task automatic run_op(input logic r, input logic w, input logic [16:0] a,
                        input logic [15:0] d, output int lat, output int we_lo,
                        output int oe_lo, output int other_lo, output int ovl);
    en = 1'b1; re = r; we = w; addr = a; data_in = d;
    lat = 0; we_lo = 0; oe_lo = 0; other_lo = 0; ovl = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin addr = ~a; data_in = ~d; end
      if (a[16]) begin
        if (!ram2WE) we_lo++;
        if (!ram2OE) oe_lo++;
        if (!ram1EN || !ram1OE || !ram1WE) other_lo++;
      end else begin
        if (!ram1WE) we_lo++;
        if (!ram1OE) oe_lo++;
        if (!ram2EN || !ram2OE || !ram2WE) other_lo++;
      end
      if ((!ram1OE && !ram1WE) || (!ram2OE && !ram2WE)) ovl++;
      if (done) break;
      lat++;
    end
  endtask

  task automatic test_reset();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (data_out !== 16'h0) begin bad++; $display("FAIL reset_data_out got=%h want=0000", data_out); end
    total++; if (ram_addr1 !== 18'h0 || ram_addr2 !== 18'h0) begin
      bad++; $display("FAIL reset_addr got=%h/%h want=0/0", ram_addr1, ram_addr2); end
    total++; if ({ram1EN, ram2EN, ram1OE, ram2OE, ram1WE, ram2WE} !== 6'b111111) begin
      bad++; $display("FAIL reset_strobes got=%b want=111111", {ram1EN, ram2EN, ram1OE, ram2OE, ram1WE, ram2WE}); end
  endtask

  task automatic test_write_read_ram1();
    int lat, wl, ol, oth, ovl;
    run_op(1'b0, 1'b1, 17'h00005, 16'h1234, lat, wl, ol, oth, ovl);
    total++; if (lat !== W_LAT) begin bad++; $display("FAIL wr1_latency got=%0d want=%0d", lat, W_LAT); end
    total++; if (wl !== WE_CYC) begin bad++; $display("FAIL wr1_we_cycles got=%0d want=%0d", wl, WE_CYC); end
    total++; if (oth !== 0 || ovl !== 0) begin bad++; $display("FAIL wr1_other_bank got=%0d ovl=%0d want=0/0", oth, ovl); end
    total++; if (ram_addr1 !== 18'h00005) begin bad++; $display("FAIL wr1_ram_addr1 got=%h want=00005", ram_addr1); end
    total++; if (mem1[5] !== 16'h1234) begin bad++; $display("FAIL wr1_mem got=%h want=1234", mem1[5]); end
    re = 1'b0; we = 1'b0; @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL wr1_done_fall got=%b want=0", done); end
    run_op(1'b1, 1'b0, 17'h00005, 16'h0000, lat, wl, ol, oth, ovl);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd1_latency got=%0d want=4", lat); end
    total++; if (ol !== 3 || wl !== 0) begin bad++; $display("FAIL rd1_oe_cycles got=%0d we=%0d want=3/0", ol, wl); end
    total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL rd1_data got=%h want=1234", data_out); end
    total++; if (oth !== 0 || ovl !== 0) begin bad++; $display("FAIL rd1_other_bank got=%0d ovl=%0d want=0/0", oth, ovl); end
    re = 1'b0; we = 1'b0; @(negedge clk);
  endtask

  task automatic test_bank2();
    int lat, wl, ol, oth, ovl;
    run_op(1'b0, 1'b1, 17'h10005, 16'hBEEF, lat, wl, ol, oth, ovl);
    total++; if (lat !== W_LAT || wl !== WE_CYC) begin
      bad++; $display("FAIL wr2_timing got=%0d/%0d want=%0d/%0d", lat, wl, W_LAT, WE_CYC); end
    total++; if (oth !== 0) begin bad++; $display("FAIL wr2_ram1_quiet got=%0d want=0", oth); end
    total++; if (mem2[5] !== 16'hBEEF || mem1[5] !== 16'h1234) begin
      bad++; $display("FAIL wr2_mem got=%h/%h want=BEEF/1234", mem2[5], mem1[5]); end
    total++; if (ram_addr2 !== 18'h00005) begin bad++; $display("FAIL wr2_ram_addr2 got=%h want=00005", ram_addr2); end
    total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL wr2_data_out_held got=%h want=1234", data_out); end
    re = 1'b0; we = 1'b0; @(negedge clk);
    run_op(1'b1, 1'b0, 17'h10005, 16'h0000, lat, wl, ol, oth, ovl);
    total++; if (data_out !== 16'hBEEF || lat !== 4) begin
      bad++; $display("FAIL rd2_data got=%h lat=%0d want=BEEF/4", data_out, lat); end
    re = 1'b0; we = 1'b0; @(negedge clk);
    run_op(1'b1, 1'b0, 17'h00005, 16'h0000, lat, wl, ol, oth, ovl);
    total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL rd1_after_bank2 got=%h want=1234", data_out); end
    re = 1'b0; we = 1'b0; @(negedge clk);
  endtask

  task automatic test_rw_both();
    int lat, wl, ol, oth, ovl;
    run_op(1'b1, 1'b1, 17'h00010, 16'h00AA, lat, wl, ol, oth, ovl);
    total++; if (lat !== W_LAT || wl !== WE_CYC || ol !== 0) begin
      bad++; $display("FAIL rw_is_write got=lat%0d we%0d oe%0d want=lat%0d we%0d oe0", lat, wl, ol, W_LAT, WE_CYC); end
    total++; if (mem1[16] !== 16'h00AA) begin bad++; $display("FAIL rw_mem got=%h want=00AA", mem1[16]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL rw_done_hold[%0d] got=%b want=1", i, done); end
    end
    re = 1'b0; we = 1'b0; @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rw_done_fall got=%b want=0", done); end
  endtask

  task automatic test_en_low();
    int act, lat;
    en = 1'b0; re = 1'b1; we = 1'b1; addr = 17'h00005; data_in = 16'hDEAD;
    act = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!ram1EN || !ram2EN || !ram1OE || !ram2OE || !ram1WE || !ram2WE || done) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL en_low_activity got=%0d want=0", act); end
    total++; if (mem1[5] !== 16'h1234) begin bad++; $display("FAIL en_low_mem got=%h want=1234", mem1[5]); end
    re = 1'b0; we = 1'b0; @(negedge clk);
    en = 1'b1; re = 1'b1; addr = 17'h10005;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) en = 1'b0;
      if (done) break;
      lat++;
    end
    total++; if (lat !== 4 || data_out !== 16'hBEEF) begin
      bad++; $display("FAIL en_drop_inflight got=lat%0d data%h want=lat4 dataBEEF", lat, data_out); end
    re = 1'b0; @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL en_drop_done_fall got=%b want=0", done); end
    en = 1'b1;
  endtask

  task automatic test_rd_wait3();
    int lat, ol, wl;
    en3 = 1'b1; re3 = 1'b1; addr = 17'h00007;
    lat = 0; ol = 0; wl = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!r1oe3) ol++;
      if (!r1we3 || !r2en3) wl++;
      if (done3) break;
      lat++;
    end
    total++; if (lat !== 6) begin bad++; $display("FAIL rw3_latency got=%0d want=6", lat); end
    total++; if (ol !== 5) begin bad++; $display("FAIL rw3_oe_cycles got=%0d want=5", ol); end
    total++; if (data_out3 !== 16'hA5A5 || wl !== 0) begin
      bad++; $display("FAIL rw3_data got=%h stray=%0d want=A5A5/0", data_out3, wl); end
    re3 = 1'b0; @(negedge clk);
    total++; if (done3 !== 1'b0) begin bad++; $display("FAIL rw3_done_fall got=%b want=0", done3); end
    en3 = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int lat, wl, ol, oth, ovl;
    en = 1'b1; we = 1'b1; re = 1'b0; addr = 17'h00020; data_in = 16'h7777;
    repeat (3) @(negedge clk);
    total++; if (ram1WE !== 1'b0) begin bad++; $display("FAIL rstw_we_low_before got=%b want=0", ram1WE); end
    #2 rst = 1'b0;
    #1;
    total++; if (ram1WE !== 1'b1 || ram1EN !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL rstw_async got=we%b en%b done%b want=1/1/0", ram1WE, ram1EN, done); end
    total++; if (ram_addr1 !== 18'h0 || data_out !== 16'h0) begin
      bad++; $display("FAIL rstw_regs got=%h/%h want=0/0", ram_addr1, data_out); end
    we = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    run_op(1'b0, 1'b1, 17'h00021, 16'h4321, lat, wl, ol, oth, ovl);
    total++; if (lat !== W_LAT || wl !== WE_CYC) begin
      bad++; $display("FAIL rstw_fresh_timing got=%0d/%0d want=%0d/%0d", lat, wl, W_LAT, WE_CYC); end
    total++; if (mem1[33] !== 16'h4321) begin bad++; $display("FAIL rstw_fresh_mem got=%h want=4321", mem1[33]); end
    re = 1'b0; we = 1'b0; @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_write_read_ram1();
    test_bank2();
    test_rw_both();
    test_en_low();
    test_rd_wait3();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_sram_responder.md
DUAL_SRAM_RESPONDER -- requirements
Module: dual_sram_responder

Interface
REQ-001 Parameter: RD_WAIT, default 1, number of extra cycles OE is held low before read data is sampled (legal range 0..7).
REQ-002 Port: clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  block enable; new requests are accepted only while high.
REQ-005 Port: re  input  1  read request, level-sensitive.
REQ-006 Port: we  input  1  write request, level-sensitive.
REQ-007 Port: addr  input  17  bit 16 selects the bank (0 = RAM1, 1 = RAM2); bits 15:0 are the word address.
REQ-008 Port: data_in  input  16  write data.
REQ-009 Port: done  output  1  operation-complete handshake.
REQ-010 Port: data_out  output  16  last read data.
REQ-011 Ports: ram_addr1 / ram_addr2  output  18  SRAM address buses.
REQ-012 Ports: ram_data1 / ram_data2  inout  16  SRAM data buses.
REQ-013 Ports: ram1EN, ram2EN, ram1OE, ram2OE, ram1WE, ram2WE  output  1 each  SRAM strobes, active-low.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, W_SETUP, W_PULSE, W_END, R_SETUP, R_WAIT, R_LATCH, DONE.
REQ-015 In IDLE with en=1, the block SHALL capture addr and data_in on the clock edge and enter W_SETUP if we=1, otherwise R_SETUP if re=1; we=1 and re=1 together SHALL be treated as a write.
REQ-016 Requests SHALL be ignored while en=0 in IDLE; an operation already in progress SHALL complete regardless of en.
REQ-017 Only the bank selected by the captured addr[16] SHALL see EN low. The other bank SHALL keep EN, OE and WE high and its data bus at Z.
REQ-018 ram_addrN SHALL be {2'b00, captured addr[15:0]}; it SHALL be held stable from the setup state until DONE.
REQ-019 Write sequence: W_SETUP drives EN low and the data bus, with WE high; W_PULSE drives WE low; W_END drives WE high with the data still driven; then DONE.
REQ-020 Write latency SHALL be done asserted 4 cycles after the accepting edge.
REQ-021 Read sequence: R_SETUP drives EN low and OE low with the data bus at Z; R_WAIT lasts RD_WAIT cycles, and is skipped when RD_WAIT=0; R_LATCH registers the bus into data_out; then DONE.
REQ-022 Read latency SHALL be done asserted 3+RD_WAIT cycles after the accepting edge.
REQ-023 OE and WE SHALL never be low together, and the data bus SHALL never be driven while OE is low.
REQ-024 All strobes SHALL be registered outputs and free of glitches.
REQ-025 In DONE, done=1 and all strobes SHALL be inactive. The FSM SHALL return to IDLE only once re=0 and we=0 (four-phase handshake); done SHALL fall on that transition.
REQ-026 data_out SHALL hold its value until the next R_LATCH; writes SHALL NOT modify it.
REQ-027 Changes to addr or data_in after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-028 When rst=0, the block SHALL immediately enter IDLE with done=0, data_out=0, ram_addr1=ram_addr2=0, all EN/OE/WE high and both data buses at Z.
REQ-029 Reset asserted mid-write SHALL release WE asynchronously with no further bus activity; the written word is then undefined.

Configuration
REQ-030 With macro SRAM_LONG_WE_EN defined, W_PULSE SHALL last 2 cycles and write latency SHALL be 5 cycles.
REQ-031 Without SRAM_LONG_WE_EN, W_PULSE SHALL last 1 cycle, as in REQ-020; read behaviour is identical in both builds.

Verification
REQ-032 Write addr=0x00005, data_in=0x1234, then read addr=0x00005 -> RAM1 WE low for exactly 1 cycle; done at +4; read returns data_out=0x1234; RAM2 strobes stay high.
REQ-033 Write 0xBEEF to addr=0x10005, then read 0x00005 -> RAM2 holds 0xBEEF; the RAM1 word is unchanged; ram_addr2=0x00005.
REQ-034 re=we=1 at addr=0x00010, data_in=0x00AA -> a write occurs; done is held while the requests stay high and falls 1 cycle after both drop.
REQ-035 RD_WAIT=3, read -> OE is low for 5 cycles and done is at +6; with en=0, the request produces no strobe activity.
REQ-036 Assert rst in W_PULSE -> WE is high within the same cycle, done=0, buses are Z; a fresh write completes normally after release; build with SRAM_LONG_WE_EN gives WE low for 2 cycles and done at +5.
